dcache_bus_arbiter: RTL and testbench
=====================================

# dcache_bus_arbiter

Shared coherence-bus arbiter and sequencer between the two per-core D-cache controllers and main memory. Each cycle it grants at most one core's bus request (GET_S / GET_M / PUT_M), broadcasts it to both controllers for snooping, and turns GET_S into either a peer cache-to-cache transfer or a memory load. It also turns PUT_M into a memory store. GET_S data is returned through an in-order response queue tagged with the requester id.

## Interface
Parameters:
- RSPQ_DEPTH, 4: response-queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- Dctrl2bus_req_en_i  in  [1:0]  per-core request valid.
- Dctrl2bus_req_tag_i  in  [1:0][`DCACHE_TAG_W-1:0]  per-core request tag.
- Dctrl2bus_req_idx_i  in  [1:0][`DCACHE_IDX_W-1:0]  per-core request index.
- Dctrl2bus_req_data_i  in  [1:0][63:0]  per-core request data (PUT_M write-back).
- Dctrl2bus_req_message_i  in  [1:0] message_t  per-core request message.
- bus2Dctrl_req_ack_o  out  [1:0]  one-hot grant to the winning core.
- bus2Dctrl_req_id_o  out  1  broadcast id of the winning core.
- bus2Dctrl_req_tag_o  out  `DCACHE_TAG_W  broadcast tag.
- bus2Dctrl_req_idx_o  out  `DCACHE_IDX_W  broadcast index.
- bus2Dctrl_req_message_o  out  message_t  broadcast message; NONE when there is no grant.
- Dctrl2bus_rsp_vld_i  in  [1:0]  per-core snoop-hit data valid.
- Dctrl2bus_rsp_data_i  in  [1:0][63:0]  per-core snoop data.
- bus2Dctrl_rsp_vld_o  out  1  response-queue head valid.
- bus2Dctrl_rsp_id_o  out  1  id of the core the head response belongs to.
- bus2Dctrl_rsp_data_o  out  64  head response data.
- Dctrl2bus_rsp_ack_i  in  [1:0]  per-core response consumed.
- bus2mem_command_o  out  2  BUS_NONE / BUS_LOAD / BUS_STORE.
- bus2mem_addr_o  out  64  memory address, {tag, idx, 3'b0}.
- bus2mem_data_o  out  64  store data.
- mem2bus_response_i  in  4  memory accept tag; 0 means not accepted.
- mem2bus_data_i  in  64  load return data.
- mem2bus_tag_i  in  4  load return tag; 0 means no return.

## Operation
- Eligibility per core i:
  - GET_M: always eligible.
  - GET_S: eligible when the memory-issue buffer (MIB) is empty and the response queue (RSPQ) count is below RSPQ_DEPTH. The count used is the registered count; a same-cycle pop does not free a slot.
  - PUT_M: eligible when the MIB is empty.
  - NONE: never eligible.
- Grant: one eligible core per cycle, chosen per Configuration. The grant drives the one-hot ack and the broadcast id/tag/idx/message in the same cycle. Ineligible or losing requests hold and retry.
- GET_M: broadcast only. It allocates no RSPQ entry and issues no memory operation; the peer invalidates.
- GET_S:
  - Allocate an RSPQ entry {id, data_vld, mem_tag, data} at the tail.
  - If the non-requesting core has Dctrl2bus_rsp_vld_i=1 in the grant cycle, capture its data and set data_vld=1.
  - Otherwise load the MIB with a LOAD and link it to the entry.
- PUT_M: load the MIB with a STORE carrying the request data. No RSPQ entry.
- MIB (1 entry): drives bus2mem_command/addr/data while valid. It clears on mem2bus_response_i≠0. For a LOAD, the accept tag is written into the linked RSPQ entry's mem_tag.
- Fill: when mem2bus_tag_i≠0, every valid entry with data_vld=0 and a matching mem_tag takes mem2bus_data_i and sets data_vld=1.
- Response: bus2Dctrl_rsp_vld_o = head valid && head data_vld. The head pops when Dctrl2bus_rsp_ack_i[head id]=1. Responses leave strictly in order.
- Pointers wrap modulo RSPQ_DEPTH. Full and empty are derived from a count of width $clog2(RSPQ_DEPTH)+1.

## Timing
- Grant, ack and broadcast: combinational, in the same cycle as the request.
- Peer-forwarded GET_S: head response is visible at the earliest on the cycle after the grant.
- Memory GET_S or PUT_M: command is driven on the cycle after the grant. It is held until accepted.
- Memory GET_S data: bus2Dctrl_rsp_vld_o asserts at the earliest on the cycle after mem2bus_tag_i matches.
- Simultaneous pop and allocate: both take effect. A memory accept and a GET_S/PUT_M grant in the same cycle: the grant is blocked, because the MIB is still valid that cycle.
- Reset, including mid-transaction:
  - Drop all RSPQ entries and the MIB; count=0; last-grant pointer=1.
  - All outputs 0, messages NONE, command BUS_NONE.
  - Memory returns after reset are ignored, because no entry matches.

## Configuration
- BUS_ARB_RR_EN defined: round-robin arbitration. The core not granted last wins ties. The pointer updates only on a grant.
- Not defined: fixed priority, core 0 always wins ties. The pointer is unused.

## Test plan
- Core 0 GET_S to tag/idx A, peer snoop vld with data 0xDEAD: ack=2'b01, no memory command; the next cycle rsp_vld=1, id=0, data 0xDEAD; ack_i[0] pops it.
- Core 1 GET_S, no peer hit: LOAD at {tag,idx,000}. Memory accepts with response=3 after 2 cycles, then returns tag=3 with 0x1234: rsp_vld the next cycle, id=1, data 0x1234.
- Both cores GET_M every cycle with BUS_ARB_RR_EN: grants alternate 01,10,01…. Without the macro: 01 every cycle.
- Core 0 PUT_M with data 0xBEEF while mem response=0 for 3 cycles: STORE held for 3 cycles; a core 1 GET_S is blocked until the accept, then granted the next cycle.
- Four GET_S with the MIB stalled: the fifth GET_S is not acked while count=4. A head pop frees a slot the following cycle.
- Assert rst with 2 entries pending and the MIB valid: outputs zero the next cycle; a later mem2bus_tag return produces no response.

Source files
------------

// File: rtl/dcache_bus_arbiter.sv
// Two-core coherence bus arbiter: grants GET_S/GET_M/PUT_M, feeds a one-entry memory-issue buffer and an in-order response queue.
// Optional macro BUS_ARB_RR_EN selects round-robin arbitration; otherwise core 0 has fixed priority.
`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 20
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 6
`endif

package dcache_bus_pkg;
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
endpackage

module dcache_bus_arbiter
  import dcache_bus_pkg::*;
#(
  parameter int RSPQ_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      Dctrl2bus_req_en_i,
  input  logic [1:0][`DCACHE_TAG_W-1:0]   Dctrl2bus_req_tag_i,
  input  logic [1:0][`DCACHE_IDX_W-1:0]   Dctrl2bus_req_idx_i,
  input  logic [1:0][63:0]                Dctrl2bus_req_data_i,
  input  message_t [1:0]                  Dctrl2bus_req_message_i,
  output logic [1:0]                      bus2Dctrl_req_ack_o,
  output logic                            bus2Dctrl_req_id_o,
  output logic [`DCACHE_TAG_W-1:0]        bus2Dctrl_req_tag_o,
  output logic [`DCACHE_IDX_W-1:0]        bus2Dctrl_req_idx_o,
  output message_t                        bus2Dctrl_req_message_o,
  input  logic [1:0]                      Dctrl2bus_rsp_vld_i,
  input  logic [1:0][63:0]                Dctrl2bus_rsp_data_i,
  output logic                            bus2Dctrl_rsp_vld_o,
  output logic                            bus2Dctrl_rsp_id_o,
  output logic [63:0]                     bus2Dctrl_rsp_data_o,
  input  logic [1:0]                      Dctrl2bus_rsp_ack_i,
  output logic [1:0]                      bus2mem_command_o,
  output logic [63:0]                     bus2mem_addr_o,
  output logic [63:0]                     bus2mem_data_o,
  input  logic [3:0]                      mem2bus_response_i,
  input  logic [63:0]                     mem2bus_data_i,
  input  logic [3:0]                      mem2bus_tag_i
);

  localparam int PW  = $clog2(RSPQ_DEPTH);
  localparam int CW  = PW + 1;
  localparam int AW  = `DCACHE_TAG_W + `DCACHE_IDX_W + 3;

  logic [RSPQ_DEPTH-1:0] r_q_vld;
  logic [RSPQ_DEPTH-1:0] r_q_dvld;
  logic [RSPQ_DEPTH-1:0] r_q_id;
  logic [3:0]            r_q_tag  [RSPQ_DEPTH];
  logic [63:0]           r_q_data [RSPQ_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic                  r_mib_vld;
  logic [1:0]            r_mib_cmd;
  logic [63:0]           r_mib_addr;
  logic [63:0]           r_mib_data;
  logic [PW-1:0]         r_mib_ptr;

  logic [1:0]            w_elig;
  logic                  w_gnt_vld;
  logic                  w_gnt_id;
  message_t              w_msg;
  logic                  w_alloc;
  logic                  w_put;
  logic                  w_hit;
  logic [63:0]           w_peer_data;
  logic [63:0]           w_addr;
  logic                  w_pop;
  logic                  w_accept;

`ifdef BUS_ARB_RR_EN
  logic                  r_last;
`endif

  // Per-core eligibility: memory-touching requests need the MIB free, GET_S also a queue slot.
  always_comb begin
    w_elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (Dctrl2bus_req_en_i[i] && !rst) begin
        case (Dctrl2bus_req_message_i[i])
          GET_M:   w_elig[i] = 1'b1;
          GET_S:   w_elig[i] = !r_mib_vld && (r_count < CW'(RSPQ_DEPTH));
          PUT_M:   w_elig[i] = !r_mib_vld;
          default: w_elig[i] = 1'b0;
        endcase
      end else begin
        w_elig[i] = 1'b0;
      end
    end
  end

  // Winner selection; the tie-break is the only difference between the two arbitration modes.
  always_comb begin
    w_gnt_vld = |w_elig;
`ifdef BUS_ARB_RR_EN
    if (&w_elig) begin
      w_gnt_id = ~r_last;
    end else begin
      w_gnt_id = w_elig[1];
    end
`else
    w_gnt_id = w_elig[1] & ~w_elig[0];
`endif
  end

  assign w_msg       = w_gnt_vld ? Dctrl2bus_req_message_i[w_gnt_id] : NONE;
  assign w_alloc     = w_gnt_vld && (w_msg == GET_S);
  assign w_put       = w_gnt_vld && (w_msg == PUT_M);
  assign w_hit       = Dctrl2bus_rsp_vld_i[~w_gnt_id];
  assign w_peer_data = Dctrl2bus_rsp_data_i[~w_gnt_id];
  assign w_addr      = {{(64-AW){1'b0}}, Dctrl2bus_req_tag_i[w_gnt_id],
                        Dctrl2bus_req_idx_i[w_gnt_id], 3'b000};
  assign w_pop       = r_q_vld[r_head] && r_q_dvld[r_head] && Dctrl2bus_rsp_ack_i[r_q_id[r_head]];
  assign w_accept    = r_mib_vld && (mem2bus_response_i != 4'd0);

  assign bus2Dctrl_req_ack_o     = w_gnt_vld ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus2Dctrl_req_id_o      = w_gnt_vld & w_gnt_id;
  assign bus2Dctrl_req_tag_o     = w_gnt_vld ? Dctrl2bus_req_tag_i[w_gnt_id] : {`DCACHE_TAG_W{1'b0}};
  assign bus2Dctrl_req_idx_o     = w_gnt_vld ? Dctrl2bus_req_idx_i[w_gnt_id] : {`DCACHE_IDX_W{1'b0}};
  assign bus2Dctrl_req_message_o = w_msg;

  assign bus2Dctrl_rsp_vld_o  = r_q_vld[r_head] & r_q_dvld[r_head];
  assign bus2Dctrl_rsp_id_o   = bus2Dctrl_rsp_vld_o & r_q_id[r_head];
  assign bus2Dctrl_rsp_data_o = bus2Dctrl_rsp_vld_o ? r_q_data[r_head] : 64'd0;

  assign bus2mem_command_o = r_mib_vld ? r_mib_cmd  : BUS_NONE;
  assign bus2mem_addr_o    = r_mib_vld ? r_mib_addr : 64'd0;
  assign bus2mem_data_o    = r_mib_vld ? r_mib_data : 64'd0;

  // Response queue entries: memory fill, accept-tag link, pop at head, allocate at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_vld  <= '0;
      r_q_dvld <= '0;
      r_q_id   <= '0;
      for (int j = 0; j < RSPQ_DEPTH; j++) begin
        r_q_tag[j]  <= 4'd0;
        r_q_data[j] <= 64'd0;
      end
    end else begin
      // Unaccepted entries keep mem_tag 0, which never matches a real return.
      for (int j = 0; j < RSPQ_DEPTH; j++) begin
        if ((mem2bus_tag_i != 4'd0) && r_q_vld[j] && !r_q_dvld[j] && (r_q_tag[j] == mem2bus_tag_i)) begin
          r_q_data[j] <= mem2bus_data_i;
          r_q_dvld[j] <= 1'b1;
        end
      end
      if (w_accept && (r_mib_cmd == BUS_LOAD)) begin
        r_q_tag[r_mib_ptr] <= mem2bus_response_i;
      end
      if (w_pop) begin
        r_q_vld[r_head] <= 1'b0;
      end
      if (w_alloc) begin
        r_q_vld[r_tail]  <= 1'b1;
        r_q_id[r_tail]   <= w_gnt_id;
        r_q_dvld[r_tail] <= w_hit;
        r_q_tag[r_tail]  <= 4'd0;
        r_q_data[r_tail] <= w_hit ? w_peer_data : 64'd0;
      end
    end
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_tail <= r_tail + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory-issue buffer: loaded by a GET_S miss or PUT_M, released on memory accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mib_vld  <= 1'b0;
      r_mib_cmd  <= BUS_NONE;
      r_mib_addr <= 64'd0;
      r_mib_data <= 64'd0;
      r_mib_ptr  <= '0;
    end else if (w_accept) begin
      r_mib_vld <= 1'b0;
    end else if (w_alloc && !w_hit) begin
      r_mib_vld  <= 1'b1;
      r_mib_cmd  <= BUS_LOAD;
      r_mib_addr <= w_addr;
      r_mib_data <= 64'd0;
      r_mib_ptr  <= r_tail;
    end else if (w_put) begin
      r_mib_vld  <= 1'b1;
      r_mib_cmd  <= BUS_STORE;
      r_mib_addr <= w_addr;
      r_mib_data <= Dctrl2bus_req_data_i[w_gnt_id];
    end else begin
      r_mib_vld <= r_mib_vld;
    end
  end

`ifdef BUS_ARB_RR_EN
  // Last-granted core, moved only when a grant happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt_vld) begin
      r_last <= w_gnt_id;
    end else begin
      r_last <= r_last;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_bus_arbiter.sv
// Scoreboard bench for dcache_bus_arbiter: directed stimulus pushes expected grants, memory commands
// and responses; negedge monitors pop and compare when the DUT presents them.
`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 20
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 6
`endif

module tb_dcache_bus_arbiter;
  import dcache_bus_pkg::*;

  localparam int TW = `DCACHE_TAG_W;
  localparam int IW = `DCACHE_IDX_W;
`ifdef BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req_en;
  logic [1:0][TW-1:0]   req_tag;
  logic [1:0][IW-1:0]   req_idx;
  logic [1:0][63:0]     req_data;
  message_t [1:0]       req_msg;
  logic [1:0]           ack_o;
  logic                 id_o;
  logic [TW-1:0]        tag_o;
  logic [IW-1:0]        idx_o;
  message_t             msg_o;
  logic [1:0]           snp_vld;
  logic [1:0][63:0]     snp_data;
  logic                 rsp_vld;
  logic                 rsp_id;
  logic [63:0]          rsp_data;
  logic [1:0]           rsp_ack;
  logic [1:0]           mem_cmd;
  logic [63:0]          mem_addr;
  logic [63:0]          mem_wdata;
  logic [3:0]           mem_resp;
  logic [63:0]          mem_rdata;
  logic [3:0]           mem_tag;

  dcache_bus_arbiter #(.RSPQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .Dctrl2bus_req_en_i(req_en), .Dctrl2bus_req_tag_i(req_tag), .Dctrl2bus_req_idx_i(req_idx),
    .Dctrl2bus_req_data_i(req_data), .Dctrl2bus_req_message_i(req_msg),
    .bus2Dctrl_req_ack_o(ack_o), .bus2Dctrl_req_id_o(id_o), .bus2Dctrl_req_tag_o(tag_o),
    .bus2Dctrl_req_idx_o(idx_o), .bus2Dctrl_req_message_o(msg_o),
    .Dctrl2bus_rsp_vld_i(snp_vld), .Dctrl2bus_rsp_data_i(snp_data),
    .bus2Dctrl_rsp_vld_o(rsp_vld), .bus2Dctrl_rsp_id_o(rsp_id), .bus2Dctrl_rsp_data_o(rsp_data),
    .Dctrl2bus_rsp_ack_i(rsp_ack),
    .bus2mem_command_o(mem_cmd), .bus2mem_addr_o(mem_addr), .bus2mem_data_o(mem_wdata),
    .mem2bus_response_i(mem_resp), .mem2bus_data_i(mem_rdata), .mem2bus_tag_i(mem_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] ack; logic [1:0] msg; logic [TW-1:0] tag; logic [IW-1:0] idx; } gnt_t;
  typedef struct packed { logic id; logic [63:0] data; } rsp_t;
  typedef struct packed { logic [1:0] cmd; logic [63:0] addr; logic [63:0] data; } mem_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  mem_t exp_mem[$];
  int   tests_run = 0;
  int   failures  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] addr_of(input logic [TW-1:0] t, input logic [IW-1:0] x);
    logic [63:0] a;
    a = 64'd0;
    a[TW+IW+2:0] = {t, x, 3'b000};
    return a;
  endfunction

  task automatic push_g(input logic [1:0] a, input message_t m, input logic [TW-1:0] t, input logic [IW-1:0] x);
    gnt_t g;
    g.ack = a; g.msg = m; g.tag = t; g.idx = x;
    exp_gnt.push_back(g);
  endtask

  task automatic push_r(input logic id, input logic [63:0] d);
    rsp_t r;
    r.id = id; r.data = d;
    exp_rsp.push_back(r);
  endtask

  task automatic push_m(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
    mem_t m;
    m.cmd = c; m.addr = a; m.data = d;
    exp_mem.push_back(m);
  endtask

  task automatic req(input int c, input message_t m, input logic [TW-1:0] t, input logic [IW-1:0] x, input logic [63:0] d);
    req_en[c] = 1'b1; req_msg[c] = m; req_tag[c] = t; req_idx[c] = x; req_data[c] = d;
  endtask

  task automatic unreq(input int c);
    req_en[c] = 1'b0; req_msg[c] = NONE;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  gnt_t mon_g;
  rsp_t mon_r;
  mem_t mon_m;

  // Grant monitor
  always @(negedge clk) begin
    if (!rst && ack_o != 2'b00) begin
      if (exp_gnt.size() == 0) begin
        chk("gnt_unexpected", 64'(ack_o), 64'd0);
      end else begin
        mon_g = exp_gnt.pop_front();
        chk("gnt_ack", 64'(ack_o), 64'(mon_g.ack));
        chk("gnt_id", 64'(id_o), 64'(mon_g.ack[1]));
        chk("gnt_msg", 64'(msg_o), 64'(mon_g.msg));
        chk("gnt_tag", 64'(tag_o), 64'(mon_g.tag));
        chk("gnt_idx", 64'(idx_o), 64'(mon_g.idx));
      end
    end
  end

  // Response monitor: compares at the cycle the head is consumed
  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_ack[rsp_id]) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
      end else begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_r.id));
        chk("rsp_data", rsp_data, mon_r.data);
      end
    end
  end

  // Memory monitor: compares at the accept cycle
  always @(negedge clk) begin
    if (!rst && mem_cmd != BUS_NONE && mem_resp != 4'd0) begin
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected", 64'(mem_cmd), 64'(BUS_NONE));
      end else begin
        mon_m = exp_mem.pop_front();
        chk("mem_cmd", 64'(mem_cmd), 64'(mon_m.cmd));
        chk("mem_addr", mem_addr, mon_m.addr);
        chk("mem_data", mem_wdata, mon_m.data);
      end
    end
  end

  localparam logic [TW-1:0] TA = 20'hA5A5A;
  localparam logic [IW-1:0] IA = 6'h15;
  localparam logic [TW-1:0] TB = 20'h12345;
  localparam logic [IW-1:0] IB = 6'h2A;

  initial begin
    logic id;
    rst = 1'b1; req_en = 2'b00; req_tag = '0; req_idx = '0; req_data = '0;
    req_msg[0] = NONE; req_msg[1] = NONE;
    snp_vld = 2'b00; snp_data = '0; rsp_ack = 2'b00;
    mem_resp = 4'd0; mem_rdata = 64'd0; mem_tag = 4'd0;
    tick(); tick(); mid();
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_msg", 64'(msg_o), 64'(NONE));
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_cmd", 64'(mem_cmd), 64'(BUS_NONE));
    chk("rst_addr", mem_addr, 64'd0);
    tick();
    rst = 1'b0;

    // Peer-forwarded GET_S
    tick();
    req(0, GET_S, TA, IA, 64'd0); snp_vld[1] = 1'b1; snp_data[1] = 64'hDEAD;
    push_g(2'b01, GET_S, TA, IA); push_r(1'b0, 64'hDEAD);
    mid();
    tick();
    unreq(0); snp_vld = 2'b00; rsp_ack[0] = 1'b1;
    mid();
    chk("t1_nocmd", 64'(mem_cmd), 64'(BUS_NONE));
    chk("t1_rsp_vld", 64'(rsp_vld), 64'd1);
    tick();
    rsp_ack = 2'b00;
    mid();
    chk("t1_popped", 64'(rsp_vld), 64'd0);

    // GET_S through memory
    tick();
    req(1, GET_S, TB, IB, 64'd0);
    push_g(2'b10, GET_S, TB, IB); push_m(BUS_LOAD, addr_of(TB, IB), 64'd0); push_r(1'b1, 64'h1234);
    mid();
    tick(); unreq(1); mid();
    chk("t2_load", 64'(mem_cmd), 64'(BUS_LOAD));
    chk("t2_addr", mem_addr, addr_of(TB, IB));
    tick(); mid();
    chk("t2_hold", 64'(mem_cmd), 64'(BUS_LOAD));
    tick(); mem_resp = 4'd3; mid();
    tick(); mem_resp = 4'd0; mid();
    chk("t2_released", 64'(mem_cmd), 64'(BUS_NONE));
    chk("t2_no_data_yet", 64'(rsp_vld), 64'd0);
    tick(); mem_tag = 4'd3; mem_rdata = 64'h1234; mid();
    chk("t2_fill_same_cycle", 64'(rsp_vld), 64'd0);
    tick(); mem_tag = 4'd0; rsp_ack[1] = 1'b1; mid();
    chk("t2_rsp_vld", 64'(rsp_vld), 64'd1);
    tick(); rsp_ack = 2'b00;

    // Both cores GET_M every cycle
    req(0, GET_M, 20'h00C0C, 6'h0C, 64'd0);
    req(1, GET_M, 20'h00D0D, 6'h0D, 64'd0);
    for (int k = 0; k < 4; k++) begin
      id = RR ? k[0] : 1'b0;
      if (id) push_g(2'b10, GET_M, 20'h00D0D, 6'h0D);
      else    push_g(2'b01, GET_M, 20'h00C0C, 6'h0C);
      mid();
      tick();
    end
    unreq(0); unreq(1);

    // PUT_M held at memory, GET_S blocked until accept
    req(0, PUT_M, 20'h0BEEF, 6'h01, 64'hBEEF);
    push_g(2'b01, PUT_M, 20'h0BEEF, 6'h01); push_m(BUS_STORE, addr_of(20'h0BEEF, 6'h01), 64'hBEEF);
    mid();
    tick();
    unreq(0); req(1, GET_S, 20'h0F00F, 6'h02, 64'd0);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t4_store_held", 64'(mem_cmd), 64'(BUS_STORE));
      chk("t4_gets_blocked", 64'(ack_o), 64'd0);
      tick();
    end
    mem_resp = 4'd5; mid();
    chk("t4_blocked_on_accept", 64'(ack_o), 64'd0);
    tick(); mem_resp = 4'd0;
    push_g(2'b10, GET_S, 20'h0F00F, 6'h02); push_m(BUS_LOAD, addr_of(20'h0F00F, 6'h02), 64'd0);
    push_r(1'b1, 64'h5555);
    mid();
    tick(); unreq(1); mem_resp = 4'd6; mid();
    chk("t4_load", 64'(mem_cmd), 64'(BUS_LOAD));
    tick(); mem_resp = 4'd0; mem_tag = 4'd6; mem_rdata = 64'h5555; mid();
    tick(); mem_tag = 4'd0; rsp_ack[1] = 1'b1; mid();
    chk("t4_rsp_vld", 64'(rsp_vld), 64'd1);
    tick(); rsp_ack = 2'b00;

    // Fill the response queue with peer hits
    req(0, GET_S, 20'h0AAAA, 6'h03, 64'd0); snp_vld[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      snp_data[1] = 64'h100 + 64'(k);
      push_g(2'b01, GET_S, 20'h0AAAA, 6'h03); push_r(1'b0, 64'h100 + 64'(k));
      mid();
      tick();
    end
    snp_data[1] = 64'h104; mid();
    chk("t5_full_blocks", 64'(ack_o), 64'd0);
    tick(); rsp_ack[0] = 1'b1; mid();
    chk("t5_pop_same_cycle_blocks", 64'(ack_o), 64'd0);
    tick(); rsp_ack[0] = 1'b0;
    push_g(2'b01, GET_S, 20'h0AAAA, 6'h03); push_r(1'b0, 64'h104);
    mid();
    tick(); unreq(0); snp_vld = 2'b00; rsp_ack[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      tick();
    end
    rsp_ack = 2'b00; mid();
    chk("t5_drained", 64'(rsp_vld), 64'd0);

    // Reset with entries pending and the MIB loaded
    tick();
    req(0, GET_S, TA, IA, 64'd0); snp_vld[1] = 1'b1; snp_data[1] = 64'h77;
    push_g(2'b01, GET_S, TA, IA);
    mid();
    tick(); unreq(0); snp_vld = 2'b00; req(1, GET_S, TB, IB, 64'd0);
    push_g(2'b10, GET_S, TB, IB);
    mid();
    tick(); unreq(1); mid();
    chk("t6_mib_loaded", 64'(mem_cmd), 64'(BUS_LOAD));
    chk("t6_head_ready", 64'(rsp_vld), 64'd1);
    tick(); rst = 1'b1;
    tick(); mid();
    chk("t6_rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("t6_rst_cmd", 64'(mem_cmd), 64'(BUS_NONE));
    chk("t6_rst_addr", mem_addr, 64'd0);
    chk("t6_rst_msg", 64'(msg_o), 64'(NONE));
    tick(); rst = 1'b0; mem_tag = 4'd7; mem_rdata = 64'h99; mid();
    tick(); mem_tag = 4'd0; mid();
    chk("t6_stale_return", 64'(rsp_vld), 64'd0);
    tick(); mid();
    chk("t6_stale_return2", 64'(rsp_vld), 64'd0);

    for (int i = 0; i < 20 && (exp_gnt.size() + exp_rsp.size() + exp_mem.size()) > 0; i++) tick();
    chk("gnt_leftover", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_leftover", 64'(exp_rsp.size()), 64'd0);
    chk("mem_leftover", 64'(exp_mem.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
